mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port if_req, input, 1: instruction-fetch request, held until if_valid.
REQ-004 SHALL have port if_addr, input, 32: fetch address.
REQ-005 SHALL have port if_rdata, output, 32: fetched word, registered.
REQ-006 SHALL have port if_valid, output, 1: one-cycle fetch completion pulse.
REQ-007 SHALL have ports mem_rd and mem_wr, input, 1 each: data load/store request, held until mem_valid; both high is illegal.
REQ-008 SHALL have ports mem_addr (input, 32), mem_wdata (input, 32), mem_size (input, 2: 0 byte, 1 half, 2 word) and mem_unsigned (input, 1: zero-extend load).
REQ-009 SHALL have ports mem_rdata (output, 32: registered load result) and mem_valid (output, 1: one-cycle pulse, also for stores).
REQ-010 SHALL have ports mmu_read and mmu_write (output, 1 each), mmu_addr (output, 32), mmu_wdata (output, 32), mmu_bytemode (output, 5) and mmu_rdata (input, 32); together these are the MMU port.
REQ-011 SHALL have port stall, output, 1: pipeline freeze.
REQ-012 SHALL have port misalign_exc, output, 1: misaligned data-access pulse.

Function
REQ-013 SHALL use FSM states IDLE, DATA and FETCH; exactly one MMU access per DATA or FETCH cycle.
REQ-014 SHALL arbitrate in IDLE: mem_rd|mem_wr goes to DATA, else if_req goes to FETCH, else stay in IDLE.
REQ-015 SHALL, on leaving DATA, go to FETCH if if_req is pending (anti-starvation), else to IDLE; on leaving FETCH, go to DATA if a data request is pending, else to IDLE.
REQ-016 SHALL ignore any request whose valid is high in the current cycle, so it is never re-served.
REQ-017 SHALL drive MMU outputs from registered request copies captured on entering a state; mmu_read/mmu_write SHALL be high only in DATA/FETCH and 0 in IDLE.
REQ-018 SHALL latch mmu_rdata on the rising edge ending DATA/FETCH into mem_rdata/if_rdata, pulse the matching valid next cycle, and give load latency of 2 cycles from request when idle.
REQ-019 SHALL set mmu_bytemode[3:0] (lane 3 = bits 31:24) as: byte 1<<addr[1:0]; half addr[1]?1100:0011; word 1111.
REQ-020 SHALL set mmu_bytemode[4] = mem_unsigned for loads and 0 for stores; fetch SHALL use mmu_bytemode 01111 with read only.
REQ-021 SHALL pass the full 32-bit address and unshifted mem_wdata; on a store mem_rdata SHALL be 0.
REQ-022 SHALL make stall combinational: (mem_rd|mem_wr)&~mem_valid | if_req&~if_valid.

Reset
REQ-023 SHALL, while rst_n is low, force immediately: state IDLE, mmu_read/mmu_write 0, valids 0, rdata regs 0, misalign_exc 0, mmu_bytemode 0, mmu_addr/mmu_wdata 0.
REQ-024 SHALL drop an access aborted by reset mid-operation without completion; requesters re-issue.

Configuration
REQ-025 SHALL, with MEM_ALIGN_CHECK_EN defined, skip the MMU access (no mmu_read/mmu_write) for a half with addr[0]=1 or a word with addr[1:0]!=0, still pass through DATA, and pulse misalign_exc with mem_valid while mem_rdata=0.
REQ-026 SHALL, without MEM_ALIGN_CHECK_EN, tie misalign_exc to 0 and ignore the low address bits not used by REQ-019.

Structure
REQ-027 SHALL place the state enum, size codes (SZ_BYTE/SZ_HALF/SZ_WORD) and bytemode constants (BM_WORD=5'b01111, BM_UNSIGNED bit) in package mem_arbiter_pkg.
REQ-028 SHALL put the bytemode computation in sub-module bytemode_gen (combinational: size, addr[1:0], unsigned, is_load -> bytemode).

Verification
REQ-029 Bench SHALL cover: lbu at 0x80000003, mmu_rdata=0xAB000000 -> mmu_bytemode=11000, mem_valid at cycle 2, mem_rdata=0xAB000000 (MMU extends).
REQ-030 Bench SHALL cover: if_req and mem_wr (sh 0x80400002, wdata 0x1234) in the same cycle -> DATA with bytemode 01100, then FETCH with 01111; stall held until if_valid in cycle 3.
REQ-031 Bench SHALL cover: continuous mem_rd plus if_req -> grants alternate DATA, FETCH, DATA, with no fetch starvation.
REQ-032 Bench SHALL cover: rst_n low during DATA -> mmu_read=0 in the same cycle, no mem_valid, and IDLE after release.
REQ-033 Bench SHALL cover: with MEM_ALIGN_CHECK_EN, lw 0x80000002 -> no MMU strobe, misalign_exc=1 and mem_valid=1 together, mem_rdata=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, access sizes, bytemode codes.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [4:0] BM_WORD     = 5'b01111;
  localparam int         BM_UNSIGNED = 4;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction
endpackage

// File: rtl/mem_arbiter_bytemode_gen.sv
// Byte-lane enables (lane 3 = bits 31:24) plus zero-extend flag for a data access; purely combinational.
module bytemode_gen
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic       is_unsigned,
  input  logic       is_load,
  output logic [4:0] bytemode
);
  logic [3:0] lanes;

  always_comb begin
    lanes = 4'b1111;
    case (size)
      SZ_BYTE: lanes = 4'b0001 << addr_lo;
      SZ_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    bytemode              = {1'b0, lanes};
    bytemode[BM_UNSIGNED] = is_load & is_unsigned;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one MMU port, one access per DATA/FETCH cycle.
// MEM_ALIGN_CHECK_EN: misaligned half/word accesses skip the MMU and pulse misalign_exc.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mmu_read,
  output logic        mmu_write,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wdata,
  output logic [4:0]  mmu_bytemode,
  input  logic [31:0] mmu_rdata,
  output logic        stall,
  output logic        misalign_exc
);
  state_t     state;
  logic       data_pend, if_pend, go_data, go_fetch, mis;
  logic [4:0] data_bm;

  // A request whose completion pulse is visible this cycle has already been served.
  assign data_pend = (mem_rd | mem_wr) & ~mem_valid;
  assign if_pend   = if_req & ~if_valid;
  assign stall     = data_pend | if_pend;

  assign go_data  = data_pend & ((state == IDLE) | (state == FETCH));
  assign go_fetch = if_pend & (((state == IDLE) & ~data_pend) | (state == DATA));

  bytemode_gen u_bytemode_gen (
    .size        (mem_size),
    .addr_lo     (mem_addr[1:0]),
    .is_unsigned (mem_unsigned),
    .is_load     (mem_rd),
    .bytemode    (data_bm)
  );

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q;
  assign mis = misaligned(mem_size, mem_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q        <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      if (go_data) mis_q <= mis;
      misalign_exc <= (state == DATA) & mis_q;
    end
  end
`else
  assign mis          = 1'b0;
  assign misalign_exc = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mmu_read     <= 1'b0;
      mmu_write    <= 1'b0;
      mmu_addr     <= '0;
      mmu_wdata    <= '0;
      mmu_bytemode <= '0;
      mem_rdata    <= '0;
      mem_valid    <= 1'b0;
      if_rdata     <= '0;
      if_valid     <= 1'b0;
    end else begin
      mem_valid <= 1'b0;
      if_valid  <= 1'b0;
      case (state)
        // Stores and skipped accesses leave mmu_read low, so they report zero.
        DATA: begin
          mem_valid <= 1'b1;
          mem_rdata <= mmu_read ? mmu_rdata : '0;
        end
        FETCH: begin
          if_valid <= 1'b1;
          if_rdata <= mmu_rdata;
        end
        default: ;
      endcase

      if (go_data) begin
        state        <= DATA;
        mmu_read     <= mem_rd & ~mis;
        mmu_write    <= mem_wr & ~mis;
        mmu_addr     <= mem_addr;
        mmu_wdata    <= mem_wdata;
        mmu_bytemode <= data_bm;
      end else if (go_fetch) begin
        state        <= FETCH;
        mmu_read     <= 1'b1;
        mmu_write    <= 1'b0;
        mmu_addr     <= if_addr;
        mmu_wdata    <= '0;
        mmu_bytemode <= BM_WORD;
      end else begin
        state        <= IDLE;
        mmu_read     <= 1'b0;
        mmu_write    <= 1'b0;
        mmu_bytemode <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected MMU grants and completions queued at drive time.
module tb_mem_arbiter;
  localparam logic [31:0] K = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [1:0]  mem_size = '0;
  logic        mem_unsigned = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mmu_read, mmu_write;
  logic [31:0] mmu_addr, mmu_wdata, mmu_rdata;
  logic [4:0]  mmu_bytemode;
  logic        stall, misalign_exc;
  logic        ovr_en = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  bm;
  } grant_t;

  grant_t      gq[$];
  logic [32:0] dq[$];
  logic [31:0] fq[$];

  assign mmu_rdata = ovr_en ? 32'hAB00_0000 : (mmu_addr ^ K);

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata),
    .mmu_bytemode(mmu_bytemode), .mmu_rdata(mmu_rdata), .stall(stall), .misalign_exc(misalign_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_bm(input logic ld, input logic [1:0] sz,
                                        input logic [31:0] a, input logic u);
    logic [3:0] l;
    if (sz == 2'd0)      l = {a[1:0] == 2'd3, a[1:0] == 2'd2, a[1:0] == 2'd1, a[1:0] == 2'd0};
    else if (sz == 2'd1) l = a[1] ? 4'hC : 4'h3;
    else                 l = 4'hF;
    return {ld & u, l};
  endfunction

  function automatic logic exp_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_data(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic u);
    grant_t g;
    logic   m;
    logic [31:0] rd;
    m = exp_mis(sz, a);
    if (!m) begin
      g.rd = ~wr; g.wr = wr; g.addr = a; g.wdata = wd; g.bm = exp_bm(~wr, sz, a, u);
      gq.push_back(g);
    end
    rd = (wr || m) ? 32'h0 : (ovr_en ? 32'hAB00_0000 : (a ^ K));
    dq.push_back({m, rd});
  endtask

  task automatic push_fetch(input logic [31:0] a);
    grant_t g;
    g.rd = 1'b1; g.wr = 1'b0; g.addr = a; g.wdata = '0; g.bm = 5'b01111;
    gq.push_back(g);
    fq.push_back(a ^ K);
  endtask

  task automatic mem_op(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic u);
    bit got = 0;
    mem_rd = ~wr; mem_wr = wr; mem_addr = a; mem_wdata = wd; mem_size = sz; mem_unsigned = u;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_valid) begin got = 1; break; end
    end
    if (!got) chk("mem_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic if_op(input logic [31:0] a);
    bit got = 0;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_valid) begin got = 1; break; end
    end
    if (!got) chk("if_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mmu_read | mmu_write) begin
        if (gq.size() == 0) chk("grant_unexp", {30'b0, mmu_read, mmu_write}, 32'd0);
        else begin
          grant_t g;
          g = gq.pop_front();
          chk("grant_rd", {31'b0, mmu_read}, {31'b0, g.rd});
          chk("grant_wr", {31'b0, mmu_write}, {31'b0, g.wr});
          chk("grant_addr", mmu_addr, g.addr);
          chk("grant_bm", {27'b0, mmu_bytemode}, {27'b0, g.bm});
          if (g.wr) chk("grant_wdata", mmu_wdata, g.wdata);
        end
      end
      if (mem_valid) begin
        if (dq.size() == 0) chk("mem_valid_unexp", 32'd1, 32'd0);
        else begin
          logic [32:0] e;
          e = dq.pop_front();
          chk("mem_rdata", mem_rdata, e[31:0]);
          chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, e[32]});
        end
      end else if (misalign_exc) chk("misalign_alone", 32'd1, 32'd0);
      if (if_valid) begin
        if (fq.size() == 0) chk("if_valid_unexp", 32'd1, 32'd0);
        else chk("if_rdata", if_rdata, fq.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mmu_rw", {30'b0, mmu_read, mmu_write}, 32'd0);
    chk("rst_valids", {30'b0, mem_valid, if_valid}, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_bm", {27'b0, mmu_bytemode}, 32'd0);
    chk("rst_addr", mmu_addr, 32'd0);
    chk("rst_wdata", mmu_wdata, 32'd0);
    chk("rst_mis", {31'b0, misalign_exc}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // lbu at the top byte lane; two-cycle latency from an idle arbiter
    ovr_en = 1'b1;
    push_data(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1);
    fork
      mem_op(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1);
      begin
        @(negedge clk);
        chk("lbu_c0_read", {31'b0, mmu_read}, 32'd0);
        chk("lbu_c0_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        chk("lbu_c1_read", {31'b0, mmu_read}, 32'd1);
        chk("lbu_c1_bm", {27'b0, mmu_bytemode}, 32'b11000);
        @(negedge clk);
        chk("lbu_c2_valid", {31'b0, mem_valid}, 32'd1);
      end
    join
    ovr_en = 1'b0;
    repeat (2) @(posedge clk); #1;

    // simultaneous store and fetch: data wins, fetch follows
    push_data(1'b1, 32'h8040_0002, 32'h0000_1234, 2'd1, 1'b0);
    push_fetch(32'h0000_1000);
    fork
      mem_op(1'b1, 32'h8040_0002, 32'h0000_1234, 2'd1, 1'b0);
      if_op(32'h0000_1000);
      begin
        logic [3:0] st_exp;
        st_exp = 4'b0111;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk($sformatf("sh_stall_c%0d", c), {31'b0, stall}, {31'b0, st_exp[c]});
          if (c == 1) chk("sh_c1_write", {31'b0, mmu_write}, 32'd1);
          if (c == 2) chk("sh_c2_fetch_bm", {27'b0, mmu_bytemode}, 32'b01111);
          if (c == 3) chk("sh_c3_if_valid", {31'b0, if_valid}, 32'd1);
        end
      end
    join
    repeat (2) @(posedge clk); #1;

    // continuous loads against continuous fetches: grants D F D F D
    push_data(1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0);
    push_fetch(32'h0000_2000);
    push_data(1'b0, 32'h0000_0104, 32'h0, 2'd2, 1'b0);
    push_fetch(32'h0000_2004);
    push_data(1'b0, 32'h0000_0108, 32'h0, 2'd2, 1'b0);
    fork
      begin
        mem_op(1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0);
        mem_op(1'b0, 32'h0000_0104, 32'h0, 2'd2, 1'b0);
        mem_op(1'b0, 32'h0000_0108, 32'h0, 2'd2, 1'b0);
      end
      begin
        if_op(32'h0000_2000);
        if_op(32'h0000_2004);
      end
    join
    repeat (2) @(posedge clk); #1;

    // assorted sizes, lanes and sign modes
    push_data(1'b1, 32'h0000_0101, 32'hDEAD_BEEF, 2'd0, 1'b0);
    mem_op(1'b1, 32'h0000_0101, 32'hDEAD_BEEF, 2'd0, 1'b0);
    push_data(1'b0, 32'h0000_0202, 32'h0, 2'd1, 1'b0);
    mem_op(1'b0, 32'h0000_0202, 32'h0, 2'd1, 1'b0);
    push_data(1'b0, 32'h0000_0300, 32'h0, 2'd1, 1'b1);
    mem_op(1'b0, 32'h0000_0300, 32'h0, 2'd1, 1'b1);
    push_fetch(32'h0000_3000);
    if_op(32'h0000_3000);
    repeat (2) @(posedge clk); #1;

    // misaligned word load: skipped with the alignment check, low bits ignored without it
    push_data(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0);
    fork
      mem_op(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("lw_mis_c1_read", {31'b0, mmu_read}, {31'b0, ~exp_mis(2'd2, 32'h8000_0002)});
        @(negedge clk);
        chk("lw_mis_c2_valid", {31'b0, mem_valid}, 32'd1);
      end
    join
    repeat (2) @(posedge clk); #1;

    // reset during DATA aborts the access
    gq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h8000_0010, wdata: 32'h0, bm: 5'b01111});
    mem_rd = 1'b1; mem_addr = 32'h8000_0010; mem_size = 2'd2; mem_unsigned = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_c1_read", {31'b0, mmu_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_read_now", {31'b0, mmu_read}, 32'd0);
    chk("abort_bm_now", {27'b0, mmu_bytemode}, 32'd0);
    chk("abort_addr_now", mmu_addr, 32'd0);
    mem_rd = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'b0, mem_valid}, 32'd0);
      chk("abort_idle", {30'b0, mmu_read, mmu_write}, 32'd0);
    end
    @(posedge clk); #1;
    push_data(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0);
    mem_op(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0);
    repeat (3) @(posedge clk); #1;

    chk("gq_empty", gq.size(), 32'd0);
    chk("dq_empty", dq.size(), 32'd0);
    chk("fq_empty", fq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
